// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM state encoding and the four standard SPI modes.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_clkgen.sv
// SCK timebase: counts half-periods of div+1 cycles and flags the leading and
// trailing SCK edges while the master is in its shifting phase.
module spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             xfer,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             lead_edge,
  output logic             trail_edge
);

  logic [DIV_W-1:0] cnt;
  logic             phase;

  assign tick       = en && (cnt == div);
  assign lead_edge  = tick && xfer && !phase;
  assign trail_edge = tick && xfer && phase;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      if (!en || tick) cnt <= '0;
      else             cnt <= cnt + DIV_W'(1);

      if (!xfer)     phase <= 1'b0;
      else if (tick) phase <= ~phase;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Full-duplex SPI master: mode/bit-order configurable, variable word length,
// one-hot active-low selects and a valid/ack receive handshake with overrun flag.
module spi_master
  import spi_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  NUM_SS = 4,
  parameter int  DIV_W  = 8,
  localparam int LEN_W  = $clog2(DATA_W),
  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [LEN_W-1:0]  word_len,
  input  logic [SS_W-1:0]   ss_select,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_overrun,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam logic [NUM_SS-1:0] SS_ONE = NUM_SS'(1);

  spi_state_t        state_q, state_d;
  logic              cpol_q, cpha_q, lsb_q;
  logic [DIV_W-1:0]  div_q;
  logic [LEN_W-1:0]  len_q, bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_next;
  logic              tick, lead_edge, trail_edge;
  logic              accept, last_bit, done, shift_ev, sample_ev;

  function automatic logic pick(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] len,
                                input logic lsb);
    return lsb ? d[0] : d[len];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .en         (state_q != IDLE),
    .xfer       (state_q == XFER),
    .div        (div_q),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  assign ready    = (state_q == IDLE);
  assign accept   = ready && start;
  assign last_bit = (bit_cnt == len_q);
  assign done     = (state_q == HOLD) && tick;
  // cpha=0 presents the first bit before SCK starts, so its final trailing edge has nothing to shift.
  assign shift_ev  = cpha_q ? lead_edge : (trail_edge && !last_bit);
  assign sample_ev = cpha_q ? trail_edge : lead_edge;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)                   state_d = SETUP;
      SETUP:   if (tick)                    state_d = XFER;
      XFER:    if (trail_edge && last_bit)  state_d = HOLD;
      HOLD:    if (tick)                    state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_next = lsb_q ? (rx_sr >> 1) : (rx_sr << 1);
    if (lsb_q) rx_next[len_q] = miso;
    else       rx_next[0]     = miso;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      div_q   <= '0;
      len_q   <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      ss_n    <= '1;
    end else begin
      state_q <= state_d;

      unique case (state_q)
        IDLE:        sck <= cpol;
        SETUP, HOLD: sck <= cpol_q;
        XFER:        if (lead_edge || trail_edge) sck <= ~sck;
        default:     sck <= cpol_q;
      endcase

      if (accept) begin
        cpol_q  <= cpol;
        cpha_q  <= cpha;
        lsb_q   <= lsb_first;
        div_q   <= clk_div;
        len_q   <= word_len;
        bit_cnt <= '0;
        rx_sr   <= '0;
        ss_n    <= ~(SS_ONE << ss_select);
        if (cpha) begin
          tx_sr <= tx_data;
        end else begin
          mosi  <= pick(tx_data, word_len, lsb_first);
          tx_sr <= advance(tx_data, lsb_first);
        end
      end else begin
        if (shift_ev) begin
          mosi  <= pick(tx_sr, len_q, lsb_q);
          tx_sr <= advance(tx_sr, lsb_q);
        end
        if (sample_ev)  rx_sr   <= rx_next;
        if (trail_edge) bit_cnt <= bit_cnt + LEN_W'(1);
        if (done) begin
          ss_n <= '1;
          mosi <= 1'b0;
        end
      end
    end
  end

  // An ack landing on the completion cycle consumes the old word, so the new one is not an overrun.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (done) begin
      rx_data    <= rx_sr;
      rx_valid   <= 1'b1;
      rx_overrun <= !rx_ack && (rx_overrun || rx_valid);
    end else if (rx_ack) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: observes SCK/MOSI/SS on the falling clock edge
// and compares against hand-computed per-transfer expectations.
module tb_spi_master;
  import spi_pkg::*;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0]  clk_div   = '0;
  logic [3:0]  word_len  = '0;
  logic [1:0]  ss_select = '0;
  logic        start     = 1'b0;
  logic [15:0] tx_data   = '0;
  logic        ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ack    = 1'b0;
  logic        rx_overrun;
  logic        sck, mosi, miso;
  logic [3:0]  ss_n;
  logic        loopback  = 1'b1;
  logic        miso_tie  = 1'b0;

  int checks = 0;
  int errors = 0;

  assign miso = loopback ? mosi : miso_tie;

  always #5 sys_clk = ~sys_clk;

  spi_master #(.DATA_W(16), .NUM_SS(4), .DIV_W(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cpol       (cpol),
    .cpha       (cpha),
    .lsb_first  (lsb_first),
    .clk_div    (clk_div),
    .word_len   (word_len),
    .ss_select  (ss_select),
    .start      (start),
    .tx_data    (tx_data),
    .ready      (ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .sck        (sck),
    .mosi       (mosi),
    .miso       (miso),
    .ss_n       (ss_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ack_word(input string tag);
    @(negedge sys_clk);
    rx_ack = 1'b1;
    @(negedge sys_clk);
    rx_ack = 1'b0;
    check({tag, "_ack_valid"}, rx_valid, 1'b0);
    check({tag, "_ack_ovr"}, rx_overrun, 1'b0);
  endtask

  // One transfer, with live inputs scrambled right after acceptance and a stray
  // start pulsed mid-transfer; ack_at>0 raises rx_ack on that ss-low cycle.
  task automatic xfer(input string tag, input spi_mode_t mode, input logic lsb,
                      input logic [7:0] div, input logic [3:0] len, input logic [1:0] sel,
                      input logic [15:0] data, input int ack_at,
                      input int exp_low, input int exp_pulses, input int exp_w,
                      input logic [15:0] exp_rx, input logic exp_ovr);
    int          low    = 0;
    int          pulses = 0;
    int          cyc    = 0;
    int          lead1  = -1;
    int          lead2  = -1;
    int          bad_ss = 0;
    int          nbits  = 0;
    logic        fin    = 1'b0;
    logic        prev_sck, prev_mosi, leading;
    logic [15:0] sent   = '0;
    logic [15:0] mask;
    logic [3:0]  ss_exp;

    ss_exp = ~(4'b0001 << sel);
    mask   = 16'hFFFF >> (15 - int'(len));

    @(negedge sys_clk);
    cpol = mode.cpol; cpha = mode.cpha; lsb_first = lsb;
    clk_div = div; word_len = len; ss_select = sel; tx_data = data;
    @(negedge sys_clk);
    check({tag, "_idle_sck"}, sck, mode.cpol);
    check({tag, "_idle_ready"}, ready, 1'b1);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    cpol = ~cpol; cpha = ~cpha; lsb_first = ~lsb_first;
    clk_div = div + 8'd5; word_len = len - 4'd1; ss_select = sel + 2'd1; tx_data = ~data;
    prev_sck  = mode.cpol;
    prev_mosi = mosi;

    for (int i = 0; i < 3000 && !fin; i++) begin
      if (ready) begin
        fin = 1'b1;
      end else begin
        cyc++;
        if (ss_n != 4'hF) low++;
        if (ss_n != ss_exp) bad_ss++;
        if (sck !== prev_sck) begin
          leading = (prev_sck == mode.cpol);
          if (leading) begin
            pulses++;
            if (lead1 < 0)      lead1 = cyc;
            else if (lead2 < 0) lead2 = cyc;
          end
          if (leading != mode.cpha) begin
            if (lsb) sent[nbits] = prev_mosi;
            else     sent = {sent[14:0], prev_mosi};
            nbits++;
          end
        end
        prev_sck  = sck;
        prev_mosi = mosi;
        rx_ack = (ack_at != 0) && (low == ack_at);
        start  = (cyc == 3);
        @(negedge sys_clk);
      end
    end
    start  = 1'b0;
    rx_ack = 1'b0;
    cpol = mode.cpol; cpha = mode.cpha; lsb_first = lsb;
    clk_div = div; word_len = len; ss_select = sel; tx_data = data;

    check({tag, "_finished"}, fin, 1'b1);
    check({tag, "_done_ss"}, ss_n, 4'hF);
    check({tag, "_done_mosi"}, mosi, 1'b0);
    check({tag, "_rx_data"}, rx_data, exp_rx);
    check({tag, "_rx_valid"}, rx_valid, 1'b1);
    check({tag, "_rx_ovr"}, rx_overrun, exp_ovr);
    check({tag, "_ss_low_cycles"}, low, exp_low);
    check({tag, "_ss_pattern"}, bad_ss, 0);
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_pulse_width"}, lead2 - lead1, exp_w);
    check({tag, "_mosi_word"}, sent, data & mask);

    repeat (3) @(negedge sys_clk);
    check({tag, "_no_queue"}, {ready, ss_n}, 5'h1F);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_ss", ss_n, 4'hF);
    check("rst_sck_mosi", {sck, mosi}, 2'b00);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_ready", ready, 1'b1);
    check("rst_rx", {rx_valid, rx_overrun}, 2'b00);
    check("rst_rx_data", rx_data, 16'h0000);

    // Mode 0 MSB-first byte with loopback.
    xfer("m0_msb", MODE0, 1'b0, 8'd0, 4'd7, 2'd0, 16'h00A5, 0, 18, 8, 2, 16'h00A5, 1'b0);
    ack_word("m0_msb");

    // Mode 3 LSB-first 16-bit word, miso held high.
    loopback = 1'b0;
    miso_tie = 1'b1;
    xfer("m3_lsb", MODE3, 1'b1, 8'd3, 4'd15, 2'd0, 16'h1234, 0, 136, 16, 8, 16'hFFFF, 1'b0);
    loopback = 1'b1;
    ack_word("m3_lsb");

    // Mode 1 on slave 2, 12-bit word.
    xfer("m1_ss2", MODE1, 1'b0, 8'd1, 4'd11, 2'd2, 16'h0ABC, 0, 52, 12, 4, 16'h0ABC, 1'b0);
    ack_word("m1_ss2");

    // Mode 2 LSB-first 5-bit word; upper tx bits must not leak into rx_data.
    xfer("m2_lsb5", MODE2, 1'b1, 8'd0, 4'd4, 2'd1, 16'hFFF5, 0, 12, 5, 2, 16'h0015, 1'b0);

    // Second completion without ack: overrun with the newer word kept.
    xfer("ovr", MODE0, 1'b0, 8'd0, 4'd7, 2'd3, 16'h003C, 0, 18, 8, 2, 16'h003C, 1'b1);
    ack_word("ovr");

    // Ack coinciding with completion while an older word is still pending.
    xfer("pre", MODE0, 1'b0, 8'd0, 4'd7, 2'd0, 16'h0011, 0, 18, 8, 2, 16'h0011, 1'b0);
    xfer("ack_done", MODE0, 1'b0, 8'd0, 4'd7, 2'd0, 16'h005A, 18, 18, 8, 2, 16'h005A, 1'b0);

    // Reset mid-transfer aborts it and clears the pending word.
    @(negedge sys_clk);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    clk_div = 8'd3; word_len = 4'd15; ss_select = 2'd0; tx_data = 16'hBEEF;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (20) @(negedge sys_clk);
    check("midrst_busy", {ready, ss_n}, 5'h0E);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_ss", ss_n, 4'hF);
    check("midrst_sck", sck, 1'b0);
    check("midrst_mosi", mosi, 1'b0);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_rx_data", rx_data, 16'h0000);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("midrst_ready", ready, 1'b1);
    check("midrst_after", {ss_n, rx_valid}, 5'h1E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
